// File: rtl/seq_sched_pkg.sv
// Shared types and defaults for the sequence-detector scheduler.
// Holds the scheduler state encoding and a width helper.
package seq_sched_pkg;

  localparam int unsigned NReqDef   = 4;
  localparam int unsigned FrameWDef = 8;
  localparam int unsigned CntWDef   = 4;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StShift,
    StDrain,
    StReport
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) begin
      res++;
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester set after i_ptr wins.
// The pointer register is owned by the caller.
module rr_arbiter
  import seq_sched_pkg::*;
#(
  parameter int unsigned N_REQ = NReqDef,
  parameter int unsigned ID_W  = clog2(NReqDef)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_id,
  output logic             o_valid
);

  logic [ID_W-1:0] w_idx;

  // Scan from ptr+1 upward with wrap; the last candidate is the pointer itself.
  always_comb begin
    o_grant = '0;
    o_id    = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      w_idx = ID_W'((32'(i_ptr) + off) % N_REQ);
      if (!o_valid && i_req[w_idx]) begin
        o_valid        = 1'b1;
        o_id           = w_idx;
        o_grant[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_detect_scheduler.sv
// Time-shares one serial Mealy detector among N_REQ requesters: grants a frame,
// clears the detector, shifts the frame MSB-first, counts hits and reports them.
module seq_detect_scheduler
  import seq_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = NReqDef,
  parameter int unsigned FRAME_W = FrameWDef,
  parameter int unsigned CNT_W   = CntWDef,
  parameter int unsigned ID_W    = clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [N_REQ*FRAME_W-1:0]   i_frame_data,
  output logic [N_REQ-1:0]           o_ack,
  output logic                       o_det_x,
  output logic                       o_det_nrst,
  input  logic                       i_det_y,
  output logic                       o_res_valid,
  output logic [ID_W-1:0]            o_res_id,
  output logic [CNT_W-1:0]           o_res_count,
  input  logic                       i_res_ready
);

  localparam int unsigned      BitW    = clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
  localparam logic [BitW-1:0]  LastBit = BitW'(FRAME_W - 1);
  localparam logic [ID_W-1:0]  PtrRst  = ID_W'(N_REQ - 1);

  state_e             r_state, w_state_d;
  logic [ID_W-1:0]    r_ptr, w_ptr_d;
  logic [FRAME_W-1:0] r_shreg, w_shreg_d;
  logic [BitW-1:0]    r_bit_cnt, w_bit_cnt_d;
  logic [CNT_W-1:0]   r_count, w_count_d;
  logic [ID_W-1:0]    r_res_id, w_res_id_d;
  logic [N_REQ-1:0]   r_ack, w_ack_d;
  logic               r_det_nrst, w_det_nrst_d;

  logic [N_REQ-1:0]   w_gnt;
  logic [ID_W-1:0]    w_gnt_id;
  logic               w_gnt_valid;
  logic [FRAME_W-1:0] w_frame_sel;
  logic               w_sample;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_arbiter (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_grant (w_gnt),
    .o_id    (w_gnt_id),
    .o_valid (w_gnt_valid)
  );

  // One-hot grant makes an AND-OR mux sufficient.
  always_comb begin
    w_frame_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_frame_sel |= i_frame_data[i*FRAME_W +: FRAME_W] & {FRAME_W{w_gnt[i]}};
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_ptr_d     = r_ptr;
    w_shreg_d   = r_shreg;
    w_bit_cnt_d = r_bit_cnt;
    w_count_d   = r_count;
    w_res_id_d  = r_res_id;
    w_ack_d     = '0;
    w_sample    = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_gnt_valid) begin
          w_state_d  = StClear;
          w_ptr_d    = w_gnt_id;
          w_res_id_d = w_gnt_id;
          w_shreg_d  = w_frame_sel;
          w_ack_d    = w_gnt;
        end
      end
      StClear: begin
        w_bit_cnt_d = '0;
        w_count_d   = '0;
        w_state_d   = StShift;
      end
      StShift: begin
        w_shreg_d = r_shreg << 1;
        // det_y lags det_x by one cycle, so the first shift cycle has nothing to sample.
        w_sample  = (r_bit_cnt != '0);
        if (r_bit_cnt == LastBit) begin
          w_state_d = StDrain;
        end else begin
          w_bit_cnt_d = r_bit_cnt + BitW'(1);
        end
      end
      StDrain: begin
        w_sample  = 1'b1;
        w_state_d = StReport;
      end
      StReport: begin
        if (i_res_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_sample && i_det_y && (r_count != CntMax)) begin
      w_count_d = r_count + CNT_W'(1);
    end

    w_det_nrst_d = (w_state_d != StClear);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= StIdle;
      r_ptr      <= PtrRst;
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_count    <= '0;
      r_res_id   <= '0;
      r_ack      <= '0;
      r_det_nrst <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_ptr      <= w_ptr_d;
      r_shreg    <= w_shreg_d;
      r_bit_cnt  <= w_bit_cnt_d;
      r_count    <= w_count_d;
      r_res_id   <= w_res_id_d;
      r_ack      <= w_ack_d;
      r_det_nrst <= w_det_nrst_d;
    end
  end

  assign o_ack       = r_ack;
  assign o_det_x     = (r_state == StShift) && r_shreg[FRAME_W-1];
  assign o_det_nrst  = r_det_nrst;
  assign o_res_valid = (r_state == StReport);
  assign o_res_id    = r_res_id;
  assign o_res_count = r_count;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Scoreboard bench for seq_detect_scheduler with a behavioural Mealy detector:
// after "11" every 0 is a hit until a 1 follows a hit, which disarms it until cleared.
module tb_seq_detect_scheduler;

  localparam int unsigned NReq   = 4;
  localparam int unsigned FrameW = 8;
  localparam int unsigned CntW   = 4;
  localparam int unsigned IdW    = 2;

  logic                     clk = 1'b0;
  logic                     nrst;
  logic [NReq-1:0]          req;
  logic [NReq*FrameW-1:0]   frame_data;
  logic [NReq-1:0]          ack;
  logic                     det_x;
  logic                     det_nrst;
  logic                     det_y;
  logic                     res_valid;
  logic [IdW-1:0]           res_id;
  logic [CntW-1:0]          res_count;
  logic                     res_ready;

  typedef struct {
    int id;
    int cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  seq_detect_scheduler #(
    .N_REQ   (NReq),
    .FRAME_W (FrameW),
    .CNT_W   (CntW),
    .ID_W    (IdW)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .i_req        (req),
    .i_frame_data (frame_data),
    .o_ack        (ack),
    .o_det_x      (det_x),
    .o_det_nrst   (det_nrst),
    .i_det_y      (det_y),
    .o_res_valid  (res_valid),
    .o_res_id     (res_id),
    .o_res_count  (res_count),
    .i_res_ready  (res_ready)
  );

  always #5 clk = ~clk;

  // Detector model: 0 idle, 1 seen 1, 2 armed (seen 11), 3 hitting, 4 disarmed.
  logic [2:0] det_st;
  always_ff @(posedge clk or negedge det_nrst) begin
    if (!det_nrst) begin
      det_st <= 3'd0;
      det_y  <= 1'b0;
    end else begin
      det_y <= ((det_st == 3'd2) || (det_st == 3'd3)) && !det_x;
      case (det_st)
        3'd0:    det_st <= det_x ? 3'd1 : 3'd0;
        3'd1:    det_st <= det_x ? 3'd2 : 3'd0;
        3'd2:    det_st <= det_x ? 3'd2 : 3'd3;
        3'd3:    det_st <= det_x ? 3'd4 : 3'd3;
        default: det_st <= 3'd4;
      endcase
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: expected event did not occur (t=%0t)", name, $time);
  endtask

  // Monitor: every accepted result must match the oldest expectation.
  always @(negedge clk) begin
    if (nrst && res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_result: got id %0d count %0d, required no result",
                 res_id, res_count);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("res_id", int'(res_id), e.id);
        chk("res_count", int'(res_count), e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic issue(input int idx, input logic [FrameW-1:0] data, input int exp_cnt);
    exp_t e;
    frame_data[idx*FrameW +: FrameW] = data;
    req[idx] = 1'b1;
    e.id  = idx;
    e.cnt = exp_cnt;
    sb_q.push_back(e);
  endtask

  task automatic wait_ack(input int idx);
    bit found;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        found = 1'b1;
        chk("ack_grant", int'(ack), 1 << idx);
      end
    end
    if (!found) fail_now("ack_timeout");
    @(posedge clk);
    #1;
    req[idx] = 1'b0;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 60 && sb_q.size() != 0; c++) begin
      @(negedge clk);
    end
    chk("drain", sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"}, int'(ack), 0);
    chk({tag, "_det_nrst"}, int'(det_nrst), 0);
    chk({tag, "_res_valid"}, int'(res_valid), 0);
    chk({tag, "_res_id"}, int'(res_id), 0);
    chk({tag, "_res_count"}, int'(res_count), 0);
    chk({tag, "_det_x"}, int'(det_x), 0);
  endtask

  initial begin
    bit seen;
    nrst       = 1'b0;
    req        = '0;
    frame_data = '0;
    res_ready  = 1'b1;

    // Reset and idle
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    @(negedge clk);
    chk("det_nrst_first", int'(det_nrst), 0);
    @(negedge clk);
    chk("det_nrst_idle", int'(det_nrst), 1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("idle_quiet", int'({res_valid, ack}), 0);
    end

    // Single frame with latency checks
    @(posedge clk);
    #1;
    issue(1, 8'b1100_0000, 6);
    @(negedge clk);
    chk("ack_T0", int'(ack), 0);
    @(negedge clk);
    chk("ack_T1", int'(ack), 4'b0010);
    @(posedge clk);
    #1;
    req[1] = 1'b0;
    repeat (8) @(negedge clk);
    @(negedge clk);
    chk("valid_T10", int'(res_valid), 0);
    @(negedge clk);
    chk("valid_T11", int'(res_valid), 1);
    wait_drain();

    // Disarm after first hit, and no hit on all-ones
    issue(2, 8'b1101_1011, 1);
    wait_ack(2);
    wait_drain();
    issue(3, 8'hFF, 0);
    wait_ack(3);
    wait_drain();

    // Round-robin: pointer at 3 -> 0 then 2; then pointer at 2 -> 3 then 0
    issue(0, 8'b0011_0000, 4);
    issue(2, 8'b1011_0100, 1);
    wait_ack(0);
    wait_ack(2);
    wait_drain();
    issue(3, 8'b0110_0110, 2);
    issue(0, 8'b1110_0001, 4);
    wait_ack(3);
    wait_ack(0);
    wait_drain();

    // Backpressure: result held for 5 cycles, pending req[3] waits
    issue(1, 8'b0111_1000, 3);
    wait_ack(1);
    res_ready = 1'b0;
    issue(3, 8'b1100_1100, 2);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    if (!seen) fail_now("bp_valid_timeout");
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      chk("bp_valid", int'(res_valid), 1);
      chk("bp_id", int'(res_id), 1);
      chk("bp_count", int'(res_count), 3);
      chk("bp_no_ack", int'(ack), 0);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    @(negedge clk);
    chk("hs_ack", int'(ack), 0);
    @(negedge clk);
    chk("idle_ack", int'(ack), 0);
    @(negedge clk);
    chk("pending_ack", int'(ack), 4'b1000);
    @(posedge clk);
    #1;
    req[3] = 1'b0;
    wait_drain();

    // Mid-frame reset at SHIFT k=4: frame aborted, pointer back to N_REQ-1
    frame_data[2*FrameW +: FrameW] = 8'b1100_0000;
    req[2] = 1'b1;
    wait_ack(2);
    repeat (4) @(posedge clk);
    #1;
    nrst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("abort");
    @(posedge clk);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("abort_quiet", int'({res_valid, ack}), 0);
    end
    issue(0, 8'b0011_0000, 4);
    issue(3, 8'hFF, 0);
    wait_ack(0);
    wait_ack(3);
    wait_drain();

    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_scheduler.md
Name: seq_detect_scheduler

Overview:
- Time-shares one serial Mealy sequence detector (MealyFSM: single-bit x in, registered y out) among N_REQ requesters.
- Each requester submits a FRAME_W-bit frame. The block round-robin arbitrates, clears the detector, shifts the frame in MSB-first and counts detector hits.
- It returns a per-frame result (requester id, hit count) through a valid/ready handshake.
- Sits between the requesting datapath blocks and the shared detector instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- FRAME_W, 8, bits per frame.
- CNT_W, 4, hit-counter width; must satisfy 2^CNT_W-1 >= FRAME_W.
- ID_W, 2, width of requester id; equals clog2(N_REQ).

Ports:
- clk  in  1  clock.
- nrst  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester frame request; held with its frame until its ack.
- frame_data  in  N_REQ*FRAME_W  requester i frame at bits [i*FRAME_W +: FRAME_W].
- ack  out  N_REQ  one-cycle pulse; frame of that requester accepted.
- det_x  out  1  serial bit to the detector x input.
- det_nrst  out  1  detector reset, active-low, registered.
- det_y  in  1  detector output y, registered in the detector.
- res_valid  out  1  result available.
- res_id  out  ID_W  requester the result belongs to.
- res_count  out  CNT_W  number of det_y=1 samples for the frame.
- res_ready  in  1  result consumer ready.

Behaviour:
- Reset is decided: nrst, asynchronous, active-low; clock clk.
- Outputs under reset:
  - ack=0, det_nrst=0 (detector held cleared), res_valid=0, res_id=0, res_count=0.
  - state=IDLE, rr pointer = N_REQ-1, so requester 0 wins first.
- det_x = shreg[FRAME_W-1] in SHIFT, else 0. It is decoded from flops only.
- FSM states: IDLE, CLEAR, SHIFT, DRAIN, REPORT.
- IDLE:
  - det_nrst=1.
  - If any req bit is set, grant the first requester set after the rr pointer (wrapping).
  - On that edge: latch its frame into shreg, set rr pointer = grant, pulse ack[grant], go to CLEAR.
  - No req: stay in IDLE.
- CLEAR (1 cycle):
  - det_nrst=0, det_x=0.
  - Bit counter and hit count cleared.
  - Next state is SHIFT.
- SHIFT (FRAME_W cycles, k=0..FRAME_W-1):
  - det_x = frame bit FRAME_W-1-k.
  - shreg shifts left by one each cycle.
  - In cycles k>=1, sample det_y; it is the response to bit k-1 (one-cycle detector latency).
  - After k=FRAME_W-1, go to DRAIN.
- DRAIN (1 cycle):
  - det_x=0.
  - Sample det_y as the response to the last bit.
  - Next state is REPORT.
- Counting: each sampled det_y=1 increments the count. The count saturates at 2^CNT_W-1 and never wraps.
- REPORT:
  - res_valid=1; res_id and res_count are stable until the handshake.
  - On res_valid&res_ready: go to IDLE, res_valid=0 next cycle.
  - res_ready already high on entry gives exactly one REPORT cycle.
- Latency: req first sampled in IDLE at cycle T gives:
  - ack high at T+1 (CLEAR);
  - SHIFT at T+2..T+FRAME_W+1;
  - DRAIN at T+FRAME_W+2;
  - res_valid at T+FRAME_W+3, i.e. T+11 with defaults.
- Boundary rules:
  - req changes outside IDLE are ignored; no queuing.
  - A req dropped before it is sampled in IDLE is never granted.
  - A requester that keeps req high after its ack is re-granted only when rr order reaches it again.
  - All requesters active gives strict rotation 0,1,2,3,0...
  - nrst asserted mid-frame aborts the frame: no result, no second ack, and the detector is cleared through det_nrst=0.
  - det_y is ignored in IDLE, CLEAR and REPORT.

Decomposition:
- Package seq_sched_pkg holds:
  - the state enum (IDLE, CLEAR, SHIFT, DRAIN, REPORT);
  - default localparams for N_REQ, FRAME_W, CNT_W;
  - a clog2 helper for ID_W.
- One sub-module, rr_arbiter: combinational priority rotation from the rr pointer, giving a one-hot grant and an encoded id. The pointer register lives in the parent.

Test Plan:
- Reset, idle behaviour: nrst low for 3 cycles, then no req -> det_nrst 0 then 1, res_valid=0, ack=0 for 20 cycles.
- Single frame, many hits: MealyFSM bound, req[1] with 8'b1100_0000 -> ack[1] at T+1, res_valid at T+11, res_id=1, res_count=6.
- Hits across a re-arm: frame 8'b1101_1011 -> res_count=1. Frame 8'hFF -> res_count=0.
- Round-robin: req[0] and req[2] together with res_ready tied high -> grants 0 then 2, res_id sequence 0,2. Next req[0]&req[3] -> grant 3 first.
- Backpressure: res_ready low 5 cycles in REPORT -> res_valid, res_id and res_count held stable; req[3] pending is not acked until one cycle after the handshake.
- Mid-frame reset: nrst pulsed low during SHIFT cycle k=4 -> outputs return to reset values, no res_valid. The next request completes with a correct count.
